// File: rtl/sprite_layer_mixer.sv
// N-sprite compositor: frame-latched sprite attributes, scaled/mirrored ROM addressing,
// ROM-latency-aligned colour-key priority mixing and per-pair collision flags.
module sprite_layer_mixer #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned COLOR_W     = 6,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned SPR_W       = 23,
  parameter int unsigned SPR_H       = 30,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ROM_LATENCY = 2,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 6'b110011,
  localparam int unsigned NUM_PAIRS  = (NUM_SPRITES > 1) ? NUM_SPRITES*(NUM_SPRITES-1)/2 : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             col,
  input  logic [COORD_W-1:0]             row,
  input  logic [COLOR_W-1:0]             bg_rgb,
  input  logic [NUM_SPRITES-1:0]         spr_enable,
  input  logic [NUM_SPRITES-1:0]         spr_mirror,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  input  logic [NUM_SPRITES*11-1:0]      spr_anim_row,
  input  logic [NUM_SPRITES*11-1:0]      spr_anim_col,
  input  logic [NUM_SPRITES*6-1:0]       spr_sheet_w,
  output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
  input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0]             out_rgb,
  output logic                           out_valid,
  output logic [NUM_PAIRS-1:0]           collide_flags,
  output logic                           collide_valid
);

  localparam int unsigned N      = NUM_SPRITES;
  localparam int unsigned LAST   = ROM_LATENCY;
  localparam logic [31:0] SPR_WS = 32'(SPR_W) << SCALE_SHIFT;
  localparam logic [31:0] SPR_HS = 32'(SPR_H) << SCALE_SHIFT;

  logic [N-1:0]         en_q, mir_q;
  logic [N*COORD_W-1:0] x_q, y_q;
  logic [N*11-1:0]      arow_q, acol_q;
  logic [N*6-1:0]       sw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      mir_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      arow_q <= '0;
      acol_q <= '0;
      sw_q   <= '0;
    end else if (frame_tick) begin
      en_q   <= spr_enable;
      mir_q  <= spr_mirror;
      x_q    <= spr_x;
      y_q    <= spr_y;
      arow_q <= spr_anim_row;
      acol_q <= spr_anim_col;
      sw_q   <= spr_sheet_w;
    end
  end

  logic [N-1:0]        inside_d;
  logic [N*ADDR_W-1:0] addr_d;
  logic [31:0]         c32, r32, x32, y32, lx, ly, cx, lin;

  // 32-bit arithmetic: the right edge never wraps past 2**COORD_W back to column 0.
  always_comb begin
    inside_d = '0;
    addr_d   = '0;
    c32      = 32'(col);
    r32      = 32'(row);
    x32      = '0;
    y32      = '0;
    lx       = '0;
    ly       = '0;
    cx       = '0;
    lin      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      x32 = 32'(x_q[i*COORD_W +: COORD_W]);
      y32 = 32'(y_q[i*COORD_W +: COORD_W]);
      lx  = (c32 - x32) >> SCALE_SHIFT;
      ly  = (r32 - y32) >> SCALE_SHIFT;
      cx  = mir_q[i] ? (32'(SPR_W) - 32'd1 - lx) : lx;
      lin = (ly + 32'(arow_q[i*11 +: 11])) * 32'(sw_q[i*6 +: 6])
            + cx + 32'(acol_q[i*11 +: 11]);
      inside_d[i] = en_q[i] && (c32 >= x32) && (c32 < x32 + SPR_WS)
                            && (r32 >= y32) && (r32 < y32 + SPR_HS);
      if (inside_d[i]) addr_d[i*ADDR_W +: ADDR_W] = lin[ADDR_W-1:0];
    end
  end

  // Index 0 is stage 1; index LAST lines up with rom_data for the same pixel.
  logic [N-1:0]       ins_q [LAST+1];
  logic [COLOR_W-1:0] bg_q  [LAST+1];
  logic [LAST:0]      vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      vld_q    <= '0;
      for (int unsigned k = 0; k <= LAST; k++) begin
        ins_q[k] <= '0;
        bg_q[k]  <= '0;
      end
    end else begin
      rom_addr <= addr_d;
      vld_q    <= {vld_q[LAST-1:0], pix_valid};
      ins_q[0] <= inside_d;
      bg_q[0]  <= bg_rgb;
      for (int unsigned k = 1; k <= LAST; k++) begin
        ins_q[k] <= ins_q[k-1];
        bg_q[k]  <= bg_q[k-1];
      end
    end
  end

  logic [N-1:0]         opaque;
  logic [COLOR_W-1:0]   rgb_d;
  logic [NUM_PAIRS-1:0] overlap_d;

  for (genvar g = 0; g < N; g++) begin : g_opaque
    assign opaque[g] = ins_q[LAST][g] && (rom_data[g*COLOR_W +: COLOR_W] != KEY_COLOR);
  end

  always_comb begin
    rgb_d = vld_q[LAST] ? bg_q[LAST] : '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (vld_q[LAST] && opaque[N-1-j]) rgb_d = rom_data[(N-1-j)*COLOR_W +: COLOR_W];
    end
  end

  if (N < 2) begin : g_no_pairs
    assign overlap_d = '0;
  end else begin : g_pairs
    for (genvar a = 0; a < N; a++) begin : g_a
      for (genvar b = a + 1; b < N; b++) begin : g_b
        localparam int unsigned P = a*(2*N-a-1)/2 + (b-a-1);
        assign overlap_d[P] = vld_q[LAST] && opaque[a] && opaque[b];
      end
    end
  end

  logic [NUM_PAIRS-1:0] accum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rgb       <= '0;
      out_valid     <= 1'b0;
      accum_q       <= '0;
      collide_flags <= '0;
      collide_valid <= 1'b0;
    end else begin
      out_rgb       <= rgb_d;
      out_valid     <= vld_q[LAST];
      collide_valid <= frame_tick;
      if (frame_tick) begin
        collide_flags <= accum_q;
        accum_q       <= overlap_d;
      end else begin
        accum_q       <= accum_q | overlap_d;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed bench for sprite_layer_mixer: addressing, mirroring, clipping, keying,
// priority, collision publishing, frame-latched attributes and mid-line reset.
module tb_sprite_layer_mixer;

  localparam logic [5:0] KEY = 6'b110011;

  logic        clk = 1'b0;
  logic        reset, frame_tick, pix_valid;
  logic [9:0]  col, row;
  logic [5:0]  bg_rgb;
  logic [1:0]  en, mir;
  logic [9:0]  x0, x1, y0, y1;
  logic [5:0]  d0, d1;
  logic [1:0]  spr_enable, spr_mirror;
  logic [19:0] spr_x, spr_y;
  logic [21:0] spr_anim_row, spr_anim_col;
  logic [11:0] spr_sheet_w;
  logic [27:0] rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  out_rgb;
  logic        out_valid;
  logic [0:0]  collide_flags;
  logic        collide_valid;
  logic [13:0] a0, a1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  assign spr_enable   = en;
  assign spr_mirror   = mir;
  assign spr_x        = {x1, x0};
  assign spr_y        = {y1, y0};
  assign spr_anim_row = '0;
  assign spr_anim_col = '0;
  assign spr_sheet_w  = {6'd46, 6'd46};
  assign rom_data     = {d1, d0};
  assign a0           = rom_addr[13:0];
  assign a1           = rom_addr[27:14];

  always #5 clk = ~clk;

  sprite_layer_mixer #(
    .NUM_SPRITES(2), .COORD_W(10), .COLOR_W(6), .ADDR_W(14), .SPR_W(23), .SPR_H(30),
    .SCALE_SHIFT(1), .ROM_LATENCY(2), .KEY_COLOR(6'b110011)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .col(col), .row(row), .bg_rgb(bg_rgb),
    .spr_enable(spr_enable), .spr_mirror(spr_mirror), .spr_x(spr_x), .spr_y(spr_y),
    .spr_anim_row(spr_anim_row), .spr_anim_col(spr_anim_col), .spr_sheet_w(spr_sheet_w),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_rgb(out_rgb), .out_valid(out_valid),
    .collide_flags(collide_flags), .collide_valid(collide_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] c, input logic [9:0] r, input logic v);
    col = c;
    row = r;
    pix_valid = v;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; pix_valid = 1'b0; col = '0; row = '0; bg_rgb = 6'd5;
    en = 2'b11; mir = 2'b00; x0 = 10'd50; y0 = 10'd290; x1 = 10'd300; y1 = 10'd100;
    d0 = 6'h2A; d1 = 6'h03;
    step(3);
    check("rst_rgb",   32'(out_rgb), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(collide_flags), 32'd0);
    check("rst_cv",    32'(collide_valid), 32'd0);
    check("rst_addr",  32'(rom_addr), 32'd0);
    reset = 1'b0;
    step(1);
    tick();

    // Basic address and four-cycle latency.
    pixel(10'd52, 10'd294, 1'b1);
    step(1);
    check("addr0_basic", 32'(a0), 32'd93);
    check("addr1_out",   32'(a1), 32'd0);
    step(2);
    check("lat_valid_lo", 32'(out_valid), 32'd0);
    step(1);
    check("lat_valid_hi", 32'(out_valid), 32'd1);
    check("rgb_s0",       32'(out_rgb), 32'h2A);

    mir = 2'b01;
    tick();
    step(1);
    check("addr0_mirror", 32'(a0), 32'd113);

    pixel(10'd49, 10'd294, 1'b1);
    step(1);
    check("addr0_c49", 32'(a0), 32'd0);
    step(3);
    check("rgb_c49", 32'(out_rgb), 32'd5);
    pixel(10'd96, 10'd294, 1'b1);
    step(1);
    check("addr0_c96", 32'(a0), 32'd0);
    step(3);
    check("rgb_c96", 32'(out_rgb), 32'd5);

    // Stack S1 under S0; transparent S0 shows S1 and does not collide.
    mir = 2'b00; x1 = 10'd50; y1 = 10'd290;
    pixel(10'd52, 10'd294, 1'b0);
    step(5);
    tick();
    check("flags_far", 32'(collide_flags), 32'd0);
    d0 = KEY; d1 = 6'b000011;
    pixel(10'd52, 10'd294, 1'b1);
    step(1);
    check("addr1_stack", 32'(a1), 32'd93);
    step(3);
    check("rgb_keyed", 32'(out_rgb), 32'b000011);
    pix_valid = 1'b0;
    step(5);
    tick();
    check("flags_keyed", 32'(collide_flags), 32'd0);
    check("cv_keyed",    32'(collide_valid), 32'd1);

    d0 = 6'h2A;
    pix_valid = 1'b1;
    step(4);
    check("rgb_prio", 32'(out_rgb), 32'h2A);
    pix_valid = 1'b0;
    step(5);
    check("flags_before_tick", 32'(collide_flags), 32'd0);
    tick();
    check("flags_hit", 32'(collide_flags), 32'd1);
    check("cv_pulse",  32'(collide_valid), 32'd1);
    step(1);
    check("cv_drop",   32'(collide_valid), 32'd0);
    check("flags_hold", 32'(collide_flags), 32'd1);
    tick();
    check("flags_clear", 32'(collide_flags), 32'd0);
    check("cv_b2b",      32'(collide_valid), 32'd1);

    // Attribute changes wait for frame_tick.
    x0 = 10'd60;
    pixel(10'd52, 10'd294, 1'b1);
    step(1);
    check("x_unlatched", 32'(a0), 32'd93);
    tick();
    step(1);
    check("x_latched_out", 32'(a0), 32'd0);
    pixel(10'd62, 10'd294, 1'b1);
    step(1);
    check("x_latched_in", 32'(a0), 32'd93);

    x0 = 10'd1010;
    tick();
    pixel(10'd5, 10'd294, 1'b1);
    step(1);
    check("no_wrap", 32'(a0), 32'd0);
    pixel(10'd1012, 10'd294, 1'b1);
    step(1);
    check("right_edge_in", 32'(a0), 32'd93);

    // Reset mid-line with live output and published collision.
    x0 = 10'd50;
    tick();
    pixel(10'd52, 10'd294, 1'b1);
    step(5);
    tick();
    check("flags_pre_rst", 32'(collide_flags), 32'd1);
    reset = 1'b1;
    #1;
    check("mrst_rgb",   32'(out_rgb), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_flags", 32'(collide_flags), 32'd0);
    check("mrst_addr",  32'(rom_addr), 32'd0);
    step(1);
    reset = 1'b0;
    step(3);
    check("post_valid_lo", 32'(out_valid), 32'd0);
    step(1);
    check("post_valid_hi", 32'(out_valid), 32'd1);
    check("post_rgb_bg",   32'(out_rgb), 32'd5);
    tick();
    step(4);
    check("post_rgb_spr",  32'(out_rgb), 32'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
